// File: rtl/game_state_ctrl.sv
// Game-flow controller for the Pacman top level.
// Tracks lives, level and the frightened (power-pill) window, detects
// pacman/ghost tile collisions and sequences the game states. The state
// output is decoded into sprite, map-writer and pill-counter resets and
// the ghost AI enable.
module game_state_ctrl #(
  parameter int NUM_GHOSTS   = 2,
  parameter int X_W          = 6,
  parameter int Y_W          = 5,
  parameter int PILL_W       = 16,
  parameter int LIVES_INIT   = 3,
  parameter int LEVEL_MAX    = 7,
  parameter int RESUME_DELAY = 250000000,
  parameter int CLEAR_DELAY  = 100000000,
  parameter int FRIGHT_TIME  = 400000000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      start,
  input  logic [X_W-1:0]            pac_x,
  input  logic [Y_W-1:0]            pac_y,
  input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  input  logic [PILL_W-1:0]         pill_count,
  input  logic                      power_eaten,
  output logic [2:0]                state,
  output logic [2:0]                lives,
  output logic [2:0]                level,
  output logic                      frightened,
  output logic [NUM_GHOSTS-1:0]     ghost_eaten,
  output logic                      sprite_reset,
  output logic                      map_wr_reset,
  output logic                      pill_reset,
  output logic                      ghost_enable
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PLAY        = 3'd1,
    ST_RESUME      = 3'd2,
    ST_LEVEL_CLEAR = 3'd3,
    ST_OVER        = 3'd4,
    ST_WON         = 3'd5
  } state_e;

  // The shared delay counter is loaded with delay-1 on entry and counts down
  // to zero, so $clog2 of the longest delay is always wide enough.
  localparam int DLY_MAX = (RESUME_DELAY > CLEAR_DELAY) ? RESUME_DELAY : CLEAR_DELAY;
  localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam int FR_W    = (FRIGHT_TIME > 1) ? $clog2(FRIGHT_TIME) : 1;

  localparam logic [CNT_W-1:0] RESUME_LOAD = CNT_W'(RESUME_DELAY - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_DELAY - 1);
  localparam logic [FR_W-1:0]  FR_LOAD     = FR_W'(FRIGHT_TIME - 1);
  localparam logic [2:0]       LIVES_RST   = 3'(LIVES_INIT);
  localparam logic [2:0]       LEVEL_TOP   = 3'(LEVEL_MAX);

  state_e                  state_q, state_d;
  logic [2:0]              lives_q, lives_d;
  logic [2:0]              level_q, level_d;
  logic                    fright_q, fright_d;
  logic [FR_W-1:0]         fr_cnt_q, fr_cnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_GHOSTS-1:0]   ghost_eaten_q, ghost_eaten_d;
  logic [NUM_GHOSTS-1:0]   hit, hit_q;
  logic                    any_hit;
  logic                    fr_eff;

  // Per-ghost tile collision against pacman's next tile.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      hit[i] = (pac_x == ghost_x[i*X_W +: X_W]) && (pac_y == ghost_y[i*Y_W +: Y_W]);
    end
  end

  assign any_hit = |hit;
  // A power pill eaten in the same cycle as a contact already protects pacman.
  assign fr_eff  = fright_q | power_eaten;

  // State, lives/level, delay counter and fright timer updates.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    lives_d       = lives_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    ghost_eaten_d = '0;
    fright_d      = 1'b0;
    fr_cnt_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_RST;
        level_d = 3'd0;
        if (start) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (pill_count == '0) begin
          if (level_q == LEVEL_TOP) begin
            state_d = ST_WON;
          end else begin
            level_d = level_q + 3'd1;
            cnt_d   = CLEAR_LOAD;
            state_d = ST_LEVEL_CLEAR;
          end
        end else if (any_hit && fr_eff) begin
          // Edge-detect per ghost so a lingering contact pulses only once.
          ghost_eaten_d = hit & ~hit_q;
        end else if (any_hit) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            cnt_d   = RESUME_LOAD;
            state_d = ST_RESUME;
          end else begin
            lives_d = 3'd0;
            state_d = ST_OVER;
          end
        end
      end

      ST_RESUME, ST_LEVEL_CLEAR: begin
        if (cnt_q == '0) state_d = ST_PLAY;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_OVER, ST_WON: begin
        if (!start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // The fright window only lives inside PLAY; leaving PLAY clears it.
    if (state_q == ST_PLAY && state_d == ST_PLAY) begin
      if (power_eaten) begin
        fright_d = 1'b1;
        fr_cnt_d = FR_LOAD;
      end else if (fright_q && fr_cnt_q != '0) begin
        fright_d = 1'b1;
        fr_cnt_d = fr_cnt_q - FR_W'(1);
      end
    end
  end

  // Registered state with synchronous reset overriding all inputs.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      lives_q       <= LIVES_RST;
      level_q       <= 3'd0;
      fright_q      <= 1'b0;
      fr_cnt_q      <= '0;
      cnt_q         <= '0;
      ghost_eaten_q <= '0;
      hit_q         <= '0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      fright_q      <= fright_d;
      fr_cnt_q      <= fr_cnt_d;
      cnt_q         <= cnt_d;
      ghost_eaten_q <= ghost_eaten_d;
      hit_q         <= hit;
    end
  end

  // Moore decode of the current state into the block resets and AI enable.
  always_comb begin
    {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b0000;
    unique case (state_q)
      ST_IDLE:        {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b1110;
      ST_PLAY:        {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b0001;
      ST_RESUME:      {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b1000;
      ST_LEVEL_CLEAR: {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b1110;
      ST_OVER,
      ST_WON:         {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b0100;
      default:        {sprite_reset, map_wr_reset, pill_reset, ghost_enable} = 4'b0000;
    endcase
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign frightened  = fright_q;
  assign ghost_eaten = ghost_eaten_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl. Expected outputs are queued when the
// stimulus for a cycle is driven and compared one clock later.
module tb_game_state_ctrl;

  localparam int NUM_GHOSTS = 2;
  localparam int X_W        = 6;
  localparam int Y_W        = 5;
  localparam int PILL_W     = 16;

  logic                      CLOCK_50 = 1'b0;
  logic                      reset;
  logic                      start;
  logic [X_W-1:0]            pac_x;
  logic [Y_W-1:0]            pac_y;
  logic [NUM_GHOSTS*X_W-1:0] ghost_x;
  logic [NUM_GHOSTS*Y_W-1:0] ghost_y;
  logic [PILL_W-1:0]         pill_count;
  logic                      power_eaten;
  logic [2:0]                state;
  logic [2:0]                lives;
  logic [2:0]                level;
  logic                      frightened;
  logic [NUM_GHOSTS-1:0]     ghost_eaten;
  logic                      sprite_reset, map_wr_reset, pill_reset, ghost_enable;

  game_state_ctrl #(
    .NUM_GHOSTS(NUM_GHOSTS), .X_W(X_W), .Y_W(Y_W), .PILL_W(PILL_W),
    .LIVES_INIT(3), .LEVEL_MAX(1),
    .RESUME_DELAY(4), .CLEAR_DELAY(3), .FRIGHT_TIME(8)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .pill_count(pill_count), .power_eaten(power_eaten),
    .state(state), .lives(lives), .level(level), .frightened(frightened),
    .ghost_eaten(ghost_eaten), .sprite_reset(sprite_reset),
    .map_wr_reset(map_wr_reset), .pill_reset(pill_reset), .ghost_enable(ghost_enable)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef enum int {S_STATE, S_LIVES, S_LEVEL, S_FRIGHT, S_GE, S_DEC} sig_e;
  typedef struct {
    sig_e       sig;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Decode values {sprite_reset, map_wr_reset, pill_reset, ghost_enable}.
  localparam logic [7:0] DEC_IDLE   = 8'b1110;
  localparam logic [7:0] DEC_PLAY   = 8'b0001;
  localparam logic [7:0] DEC_RESUME = 8'b1000;
  localparam logic [7:0] DEC_CLEAR  = 8'b1110;
  localparam logic [7:0] DEC_END    = 8'b0100;

  function automatic logic [7:0] observe(input sig_e s);
    case (s)
      S_STATE:  return {5'b0, state};
      S_LIVES:  return {5'b0, lives};
      S_LEVEL:  return {5'b0, level};
      S_FRIGHT: return {7'b0, frightened};
      S_GE:     return {6'b0, ghost_eaten};
      default:  return {4'b0, sprite_reset, map_wr_reset, pill_reset, ghost_enable};
    endcase
  endfunction

  task automatic expect_val(input sig_e s, input logic [7:0] v, input string tag);
    exp_t e;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare everything queued for this cycle.
  task automatic tick();
    exp_t       e;
    logic [7:0] obs;
    @(posedge CLOCK_50);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic ghost_on(input int i);
    ghost_x[i*X_W +: X_W] = pac_x;
    ghost_y[i*Y_W +: Y_W] = pac_y;
  endtask

  task automatic ghost_off(input int i);
    ghost_x[i*X_W +: X_W] = X_W'(i + 1);
    ghost_y[i*Y_W +: Y_W] = Y_W'(i + 1);
  endtask

  // After the RESUME entry edge: three more RESUME cycles, then PLAY.
  task automatic finish_resume(input logic [7:0] exp_lives, input string tag);
    for (int k = 0; k < 3; k++) begin
      expect_val(S_STATE, 8'd2, {tag, "_hold"});
      expect_val(S_DEC, DEC_RESUME, {tag, "_dec"});
      tick();
    end
    expect_val(S_STATE, 8'd1, {tag, "_back_play"});
    expect_val(S_LIVES, exp_lives, {tag, "_lives"});
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    pac_x       = X_W'(10);
    pac_y       = Y_W'(10);
    ghost_x     = '0;
    ghost_y     = '0;
    ghost_off(0);
    ghost_off(1);
    pill_count  = PILL_W'(10);
    power_eaten = 1'b0;

    // Reset state
    expect_val(S_STATE, 8'd0, "rst_state");
    expect_val(S_LIVES, 8'd3, "rst_lives");
    expect_val(S_LEVEL, 8'd0, "rst_level");
    expect_val(S_FRIGHT, 8'd0, "rst_fright");
    expect_val(S_GE, 8'd0, "rst_ge");
    expect_val(S_DEC, DEC_IDLE, "rst_dec");
    tick();

    reset = 1'b0;
    start = 1'b1;
    expect_val(S_STATE, 8'd1, "start_play");
    expect_val(S_DEC, DEC_PLAY, "play_dec");
    tick();

    // Death and resume; collisions and power pills ignored in RESUME
    ghost_on(0);
    expect_val(S_STATE, 8'd2, "death1_state");
    expect_val(S_LIVES, 8'd2, "death1_lives");
    expect_val(S_DEC, DEC_RESUME, "death1_dec");
    tick();
    power_eaten = 1'b1;
    expect_val(S_STATE, 8'd2, "resume_hit_ignored");
    expect_val(S_LIVES, 8'd2, "resume_lives_kept");
    expect_val(S_FRIGHT, 8'd0, "resume_power_ignored");
    tick();
    power_eaten = 1'b0;
    ghost_off(0);
    for (int k = 0; k < 2; k++) begin
      expect_val(S_STATE, 8'd2, "resume1_hold");
      tick();
    end
    expect_val(S_STATE, 8'd1, "resume1_done");
    expect_val(S_FRIGHT, 8'd0, "resume1_fright");
    tick();

    // Second death, then final death to OVER
    ghost_on(0);
    expect_val(S_STATE, 8'd2, "death2_state");
    expect_val(S_LIVES, 8'd1, "death2_lives");
    tick();
    ghost_off(0);
    finish_resume(8'd1, "resume2");

    ghost_on(0);
    expect_val(S_STATE, 8'd4, "over_state");
    expect_val(S_LIVES, 8'd0, "over_lives");
    expect_val(S_DEC, DEC_END, "over_dec");
    tick();
    power_eaten = 1'b1;
    expect_val(S_STATE, 8'd4, "over_hold");
    expect_val(S_LIVES, 8'd0, "over_lives_hold");
    expect_val(S_FRIGHT, 8'd0, "over_power_ignored");
    tick();
    power_eaten = 1'b0;
    ghost_off(0);
    start = 1'b0;
    expect_val(S_STATE, 8'd0, "over_to_idle");
    tick();
    expect_val(S_STATE, 8'd0, "idle_hold");
    expect_val(S_LIVES, 8'd3, "idle_lives_reload");
    expect_val(S_DEC, DEC_IDLE, "idle_dec");
    tick();

    // Frightened window with a lingering ghost contact
    start = 1'b1;
    expect_val(S_STATE, 8'd1, "restart_play");
    expect_val(S_LIVES, 8'd3, "restart_lives");
    tick();
    power_eaten = 1'b1;
    expect_val(S_FRIGHT, 8'd1, "fr_set");
    tick();
    power_eaten = 1'b0;
    ghost_on(1);
    expect_val(S_GE, 8'b10, "fr_eat_g1");
    expect_val(S_LIVES, 8'd3, "fr_eat_lives");
    expect_val(S_STATE, 8'd1, "fr_eat_state");
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_val(S_GE, 8'd0, "fr_eat_once");
      expect_val(S_STATE, 8'd1, "fr_contact_state");
      expect_val(S_LIVES, 8'd3, "fr_contact_lives");
      tick();
    end
    ghost_off(1);
    for (int k = 0; k < 2; k++) begin
      expect_val(S_FRIGHT, 8'd1, "fr_still_on");
      tick();
    end
    expect_val(S_FRIGHT, 8'd0, "fr_expire");
    expect_val(S_STATE, 8'd1, "fr_expire_state");
    tick();
    ghost_on(1);
    expect_val(S_STATE, 8'd2, "post_fr_death");
    expect_val(S_LIVES, 8'd2, "post_fr_lives");
    tick();
    ghost_off(1);
    finish_resume(8'd2, "resume3");

    // Level clear beats a simultaneous hit; lives preserved
    pill_count = '0;
    ghost_on(0);
    expect_val(S_STATE, 8'd3, "clear_state");
    expect_val(S_LEVEL, 8'd1, "clear_level");
    expect_val(S_LIVES, 8'd2, "clear_lives");
    expect_val(S_DEC, DEC_CLEAR, "clear_dec");
    tick();
    pill_count = PILL_W'(10);
    ghost_off(0);
    for (int k = 0; k < 2; k++) begin
      expect_val(S_STATE, 8'd3, "clear_hold");
      expect_val(S_DEC, DEC_CLEAR, "clear_pill_reset");
      tick();
    end
    expect_val(S_STATE, 8'd1, "clear_done");
    expect_val(S_LEVEL, 8'd1, "clear_done_level");
    tick();

    // Power pill and hit in the same cycle, then a retrigger at t=5
    power_eaten = 1'b1;
    ghost_on(0);
    expect_val(S_GE, 8'b01, "same_cycle_eat");
    expect_val(S_FRIGHT, 8'd1, "same_cycle_fright");
    expect_val(S_LIVES, 8'd2, "same_cycle_lives");
    expect_val(S_STATE, 8'd1, "same_cycle_state");
    tick();
    power_eaten = 1'b0;
    ghost_off(0);
    for (int k = 1; k <= 4; k++) begin
      expect_val(S_FRIGHT, 8'd1, "retrig_pre");
      expect_val(S_GE, 8'd0, "retrig_ge_idle");
      tick();
    end
    power_eaten = 1'b1;
    expect_val(S_FRIGHT, 8'd1, "retrig_pulse");
    tick();
    power_eaten = 1'b0;
    for (int k = 6; k <= 12; k++) begin
      expect_val(S_FRIGHT, 8'd1, "retrig_extended");
      tick();
    end
    expect_val(S_FRIGHT, 8'd0, "retrig_expire");
    tick();

    // Reset during RESUME with counter at 2
    ghost_on(0);
    expect_val(S_STATE, 8'd2, "death4_state");
    expect_val(S_LIVES, 8'd1, "death4_lives");
    expect_val(S_LEVEL, 8'd1, "death4_level");
    tick();
    ghost_off(0);
    expect_val(S_STATE, 8'd2, "death4_hold");
    tick();
    reset = 1'b1;
    expect_val(S_STATE, 8'd0, "midrst_state");
    expect_val(S_LIVES, 8'd3, "midrst_lives");
    expect_val(S_LEVEL, 8'd0, "midrst_level");
    expect_val(S_FRIGHT, 8'd0, "midrst_fright");
    expect_val(S_DEC, DEC_IDLE, "midrst_dec");
    tick();
    expect_val(S_STATE, 8'd0, "rst_overrides_start");
    tick();
    reset = 1'b0;
    expect_val(S_STATE, 8'd1, "post_rst_play");
    tick();

    // Clear level 0, then clear the last level to WON
    pill_count = '0;
    ghost_on(0);
    expect_val(S_STATE, 8'd3, "clear2_state");
    expect_val(S_LEVEL, 8'd1, "clear2_level");
    expect_val(S_LIVES, 8'd3, "clear2_lives");
    tick();
    pill_count = PILL_W'(10);
    ghost_off(0);
    for (int k = 0; k < 2; k++) begin
      expect_val(S_STATE, 8'd3, "clear2_hold");
      tick();
    end
    expect_val(S_STATE, 8'd1, "clear2_done");
    tick();
    pill_count = '0;
    ghost_on(0);
    expect_val(S_STATE, 8'd5, "won_state");
    expect_val(S_LEVEL, 8'd1, "won_level");
    expect_val(S_LIVES, 8'd3, "won_lives");
    expect_val(S_DEC, DEC_END, "won_dec");
    tick();
    pill_count = PILL_W'(10);
    ghost_off(0);
    expect_val(S_STATE, 8'd5, "won_hold");
    expect_val(S_LEVEL, 8'd1, "won_level_hold");
    tick();
    start = 1'b0;
    expect_val(S_STATE, 8'd0, "won_to_idle");
    tick();
    expect_val(S_LEVEL, 8'd0, "idle_level_reload");
    expect_val(S_LIVES, 8'd3, "idle_lives_reload2");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised game-flow controller for the Pacman top level. It tracks lives, level and a frightened (power-pill) mode, and detects pacman/ghost tile collisions across NUM_GHOSTS ghosts. It sequences IDLE/PLAY/RESUME/LEVEL_CLEAR/OVER/WON and drives the sprite, map-writer and pill-counter resets plus the ghost AI enable.

Parameters:
NUM_GHOSTS, 2, number of ghosts compared against pacman (1..8)
X_W, 6, tile x coordinate width
Y_W, 5, tile y coordinate width
PILL_W, 16, pill_count width
LIVES_INIT, 3, lives loaded in IDLE (1..7)
LEVEL_MAX, 7, last level index; clearing it reaches WON
RESUME_DELAY, 250000000, cycles spent in RESUME after a death (>=1)
CLEAR_DELAY, 100000000, cycles spent in LEVEL_CLEAR (>=1)
FRIGHT_TIME, 400000000, frightened duration in cycles (>=1)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high; overrides all other inputs
start  in  1  level-sensitive start switch
pac_x  in  X_W  pacman next tile x
pac_y  in  Y_W  pacman next tile y
ghost_x  in  NUM_GHOSTS*X_W  ghost next tile x; ghost i is in slice [i*X_W +: X_W]
ghost_y  in  NUM_GHOSTS*Y_W  ghost next tile y; same slicing
pill_count  in  PILL_W  pills remaining on map
power_eaten  in  1  one-cycle pulse when a power pill is eaten
state  out  3  IDLE=0, PLAY=1, RESUME=2, LEVEL_CLEAR=3, OVER=4, WON=5
lives  out  3  remaining lives
level  out  3  current level (0-based)
frightened  out  1  ghosts vulnerable
ghost_eaten  out  NUM_GHOSTS  one-cycle pulse per ghost eaten
sprite_reset, map_wr_reset, pill_reset, ghost_enable  out  1 each  Moore decode of state

Behaviour:
- Reset values: state=IDLE, lives=LIVES_INIT, level=0, frightened=0, ghost_eaten=0, internal counters=0, hit_q=0.
- hit[i] = (pac_x==ghost_x[i]) & (pac_y==ghost_y[i]); combinational; hit_q registers hit every cycle.
- Moore decode, as sprite_reset/map_wr_reset/pill_reset/ghost_enable:
  - IDLE 1/1/1/0
  - PLAY 0/0/0/1
  - RESUME 1/0/0/0
  - LEVEL_CLEAR 1/1/1/0
  - OVER and WON 0/1/0/0
- IDLE: lives<=LIVES_INIT, level<=0 every cycle. start==1 -> PLAY next cycle.
- PLAY: one action per cycle, evaluated in this priority order:
  1. pill_count==0: if level==LEVEL_MAX -> WON. Otherwise level<=level+1, load counter CLEAR_DELAY-1, go LEVEL_CLEAR.
  2. Any hit while fr_eff (fr_eff = frightened | power_eaten): stay PLAY. ghost_eaten[i]<=hit[i] & ~hit_q[i], so each ghost pulses once per contact.
  3. Any hit while ~fr_eff: if lives>1, lives<=lives-1, load counter RESUME_DELAY-1, go RESUME. If lives==1, lives<=0, go OVER.
  4. Otherwise stay PLAY.
- ghost_eaten is 0 in every cycle not covered by rule 2.
- Frightened timer:
  - power_eaten in PLAY sets frightened=1 and loads the fright counter with FRIGHT_TIME-1. A retrigger reloads the counter.
  - While frightened, the counter decrements once per cycle. Reaching 0 with no power_eaten clears frightened the next cycle, giving FRIGHT_TIME cycles total.
  - Leaving PLAY clears frightened and the fright counter.
  - power_eaten outside PLAY is ignored.
- RESUME: counter decrements each cycle. When the counter is 0, go PLAY, so RESUME lasts exactly RESUME_DELAY cycles. Collisions are ignored.
- LEVEL_CLEAR: same counter mechanism with CLEAR_DELAY, then go PLAY. Lives are preserved.
- OVER, WON: hold all state. start==0 -> IDLE, so a restart is a toggle of start off then on.
- Counter width is $clog2 of the largest delay; no wrap, because the counter is only reloaded on entry.
- lives never underflows: it only decrements when lives>1, or is set to 0 on the final death.
- level saturates by construction; it is never incremented beyond LEVEL_MAX.
- reset asserted mid-operation, in any state, returns to the reset values on the next edge.

Test Plan:
Common parameters: NUM_GHOSTS=2, RESUME_DELAY=4, CLEAR_DELAY=3, FRIGHT_TIME=8, LEVEL_MAX=1, LIVES_INIT=3.
1. Death and resume: reset, start=1, pill_count=10, ghost0 set to pac tile for 1 cycle. Required: state=RESUME next cycle, lives=2, ghost_enable=0, sprite_reset=1. state=PLAY after exactly 4 RESUME cycles.
2. Game over: three separate collisions, each after its RESUME completes. Required: lives 3->2->1->0, state=OVER after the third, ghost_enable=0. Then start=0 -> IDLE with lives=3.
3. Frightened window: power_eaten pulse, then ghost1 held on pac tile for 5 cycles. Required: a single 1-cycle ghost_eaten=2'b10, lives stay 3, state stays PLAY. frightened drops exactly 8 cycles after the pulse. A fresh hit after that -> RESUME.
4. Simultaneous events: same cycle pill_count=0 and ghost hit at level 0 -> LEVEL_CLEAR, level=1, lives=3, pill_reset=1 for 3 cycles, then PLAY. Same again at level 1 -> WON. Same cycle power_eaten and hit -> ghost eaten, no death.
5. Retrigger and reset mid-operation: power_eaten at t=0 and t=5 -> frightened until t=13. Reset asserted during RESUME with counter at 2 -> state=IDLE, lives=3, level=0, frightened=0 next edge.
